hazard_scoreboard: RTL and testbench

// Parametrised RAW-hazard scoreboard and stall/flush controller for the in-order pipeline.

---
 rtl/hazard_scoreboard.sv | 70 +++++++
 tb/tb_hazard_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW-hazard scoreboard and stall/flush controller beside decode.
module hazard_scoreboard #(
  parameter int NUM_REGS    = 8,
  parameter int SEL_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter int NUM_RD      = 2,
  parameter int NUM_WR      = 2,
  parameter int DEPTH       = 2,
  parameter int FLUSH_STAGE = 1,
  parameter bit BYPASS_LAST = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NUM_RD*SEL_W-1:0]  id_rs_sel,
  input  logic [NUM_RD-1:0]        id_rs_en,
  input  logic [NUM_WR*SEL_W-1:0]  id_wr_sel,
  input  logic [NUM_WR-1:0]        id_wr_en,
  input  logic                     flush,
  input  logic                     stall_ext,
  input  logic                     stall_cnt_clr,
  output logic                     id_issue,
  output logic                     stall,
  output logic [NUM_REGS-1:0]      pending_mask,
  output logic [CNT_W-1:0]         stall_count
);
  localparam int VIS = BYPASS_LAST ? DEPTH - 1 : DEPTH;
  logic [DEPTH-1:0]                   s_valid;
  logic [DEPTH-1:0][NUM_WR-1:0]       s_wen;
  logic [DEPTH-1:0][NUM_WR*SEL_W-1:0] s_sel;
  logic                               hazard;
  // Selects at or above NUM_REGS never match because r only spans real registers.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < NUM_WR; k++)
        for (int r = 0; r < NUM_REGS; r++)
          if (i < VIS && !reset && s_valid[i] && s_wen[i][k] &&
              s_sel[i][k*SEL_W +: SEL_W] == SEL_W'(r))
            pending_mask[r] = 1'b1;
    hazard = 1'b0;
    for (int k = 0; k < NUM_RD; k++)
      if (id_rs_en[k] && int'(id_rs_sel[k*SEL_W +: SEL_W]) < NUM_REGS &&
          pending_mask[id_rs_sel[k*SEL_W +: SEL_W]])
        hazard = 1'b1;
    hazard = hazard && id_valid;
  end
  assign stall    = (hazard || stall_ext) && !flush && !reset;
  assign id_issue = id_valid && !stall && !flush && !reset;
  // Slots keep shifting during a stall; a flush kills entries leaving slots below FLUSH_STAGE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_valid     <= '0;
      s_wen       <= '0;
      s_sel       <= '0;
      stall_count <= '0;
    end else begin
      s_valid[0] <= id_issue;
      s_wen[0]   <= id_issue ? id_wr_en : '0;
      s_sel[0]   <= id_wr_sel;
      for (int i = 1; i < DEPTH; i++) begin
        s_valid[i] <= s_valid[i-1] && !(flush && (i - 1) < FLUSH_STAGE);
        s_wen[i]   <= (flush && (i - 1) < FLUSH_STAGE) ? '0 : s_wen[i-1];
        s_sel[i]   <= s_sel[i-1];
      end
      stall_count <= stall_cnt_clr ? '0 :
                     (stall && stall_count != '1) ? stall_count + 1'b1 : stall_count;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of two scoreboard configurations sharing one stimulus.
module tb_hazard_scoreboard;
  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_rs_sel;
  logic [1:0] id_rs_en;
  logic [5:0] id_wr_sel;
  logic [1:0] id_wr_en;
  logic       flush;
  logic       stall_ext;
  logic       stall_cnt_clr;
  logic       a_issue, a_stall, b_issue, b_stall;
  logic [7:0] a_pm, b_pm;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  hazard_scoreboard u_a (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs_sel(id_rs_sel),
    .id_rs_en(id_rs_en), .id_wr_sel(id_wr_sel), .id_wr_en(id_wr_en), .flush(flush),
    .stall_ext(stall_ext), .stall_cnt_clr(stall_cnt_clr), .id_issue(a_issue),
    .stall(a_stall), .pending_mask(a_pm), .stall_count(a_cnt)
  );

  hazard_scoreboard #(.BYPASS_LAST(1'b0), .CNT_W(2)) u_b (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs_sel(id_rs_sel),
    .id_rs_en(id_rs_en), .id_wr_sel(id_wr_sel), .id_wr_en(id_wr_en), .flush(flush),
    .stall_ext(stall_ext), .stall_cnt_clr(stall_cnt_clr), .id_issue(b_issue),
    .stall(b_stall), .pending_mask(b_pm), .stall_count(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_sel = '0; id_rs_en = '0; id_wr_sel = '0; id_wr_en = '0;
    flush = 0; stall_ext = 0; stall_cnt_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    #2;
    chk("rst_a_pm", a_pm, 8'h00);
    chk("rst_a_cnt", a_cnt, 16'd0);
    chk("rst_b_cnt", b_cnt, 2'd0);
    id_valid = 1; stall_ext = 1;
    #1;
    chk("rst_a_stall", a_stall, 1'b0);
    chk("rst_a_issue", a_issue, 1'b0);
    do_reset();

    // I1 writes r0, I2 reads r0: bypass config stalls once, no-bypass config twice
    id_valid = 1; id_wr_en = 2'b01; id_wr_sel = {3'd0, 3'd0};
    #1;
    chk("raw_i1_issue", a_issue, 1'b1);
    tick();
    id_wr_en = 2'b00; id_rs_en = 2'b01; id_rs_sel = {3'd0, 3'd0};
    #1;
    chk("raw_c1_a_pm", a_pm, 8'h01);
    chk("raw_c1_a_stall", a_stall, 1'b1);
    chk("raw_c1_a_issue", a_issue, 1'b0);
    chk("raw_c1_b_pm", b_pm, 8'h01);
    chk("raw_c1_b_stall", b_stall, 1'b1);
    tick();
    #1;
    chk("raw_c2_a_stall", a_stall, 1'b0);
    chk("raw_c2_a_issue", a_issue, 1'b1);
    chk("raw_c2_a_pm", a_pm, 8'h00);
    chk("raw_c2_b_stall", b_stall, 1'b1);
    chk("raw_c2_b_pm", b_pm, 8'h01);
    tick();
    #1;
    chk("raw_c3_a_cnt", a_cnt, 16'd1);
    chk("raw_c3_b_stall", b_stall, 1'b0);
    chk("raw_c3_b_issue", b_issue, 1'b1);
    chk("raw_c3_b_pm", b_pm, 8'h00);
    tick();
    chk("raw_b_cnt", b_cnt, 2'd2);
    chk("raw_a_cnt_hold", a_cnt, 16'd1);
    do_reset();

    // Two write ports: r3 on port 0, r5 on port 1
    id_valid = 1; id_wr_en = 2'b11; id_wr_sel = {3'd5, 3'd3};
    tick();
    id_wr_en = 2'b00; id_rs_en = 2'b10; id_rs_sel = {3'd5, 3'd0};
    #1;
    chk("dual_pm", a_pm, 8'h28);
    chk("dual_r5_stall", a_stall, 1'b1);
    id_rs_en = 2'b10; id_rs_sel = {3'd0, 3'd3};
    #1;
    chk("dual_disabled_port", a_stall, 1'b0);
    id_rs_en = 2'b11; id_rs_sel = {3'd6, 3'd4};
    #1;
    chk("dual_r4r6_stall", a_stall, 1'b0);
    chk("dual_r4r6_issue", a_issue, 1'b1);
    do_reset();

    // Flush in the same cycle as a hazard stall
    id_valid = 1; id_wr_en = 2'b01; id_wr_sel = {3'd0, 3'd0};
    tick();
    id_wr_en = 2'b00; id_rs_en = 2'b01; id_rs_sel = {3'd0, 3'd0}; flush = 1;
    #1;
    chk("flush_stall", a_stall, 1'b0);
    chk("flush_issue", a_issue, 1'b0);
    tick();
    idle();
    #1;
    chk("flush_a_pm", a_pm, 8'h00);
    chk("flush_b_slot1_bubble", b_pm, 8'h00);
    chk("flush_a_cnt", a_cnt, 16'd0);
    do_reset();

    // External stall inserts bubbles; small counter saturates; clear beats increment
    id_valid = 1; id_wr_en = 2'b01; id_wr_sel = {3'd0, 3'd2}; stall_ext = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ext_stall", a_stall, 1'b1);
      chk("ext_issue", a_issue, 1'b0);
      tick();
    end
    chk("ext_a_cnt3", a_cnt, 16'd3);
    chk("ext_b_cnt3", b_cnt, 2'd3);
    chk("ext_a_pm_bubbles", a_pm, 8'h00);
    chk("ext_b_pm_bubbles", b_pm, 8'h00);
    tick();
    chk("ext_a_cnt4", a_cnt, 16'd4);
    chk("ext_b_sat", b_cnt, 2'd3);
    stall_cnt_clr = 1;
    tick();
    chk("clr_a_cnt", a_cnt, 16'd0);
    chk("clr_b_cnt", b_cnt, 2'd0);
    stall_cnt_clr = 0; stall_ext = 0;
    #1;
    chk("ext_release_issue", a_issue, 1'b1);
    do_reset();

    // Reset while r1 and r2 are pending
    id_valid = 1; id_wr_en = 2'b11; id_wr_sel = {3'd2, 3'd1};
    tick();
    idle();
    #1;
    chk("mid_pm_before", a_pm, 8'h06);
    id_valid = 1; id_rs_en = 2'b01; id_rs_sel = {3'd0, 3'd1};
    reset = 1;
    #1;
    chk("mid_a_pm", a_pm, 8'h00);
    chk("mid_b_pm", b_pm, 8'h00);
    chk("mid_a_stall", a_stall, 1'b0);
    tick();
    reset = 0;
    #1;
    chk("post_a_stall", a_stall, 1'b0);
    chk("post_a_issue", a_issue, 1'b1);
    chk("post_b_issue", b_issue, 1'b1);
    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
